// File: rtl/div7_job_arbiter.sv
// div7_job_arbiter: round-robin A/B job arbiter feeding a div-by-7 engine.
// Optional WAIT watchdog enabled by defining DIV7_ARB_TIMEOUT_EN.
module div7_job_arbiter (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Req_A,
  input  logic         Req_B,
  input  logic [127:0] Img_A,
  input  logic [127:0] Img_B,
  input  logic         Ack_A,
  input  logic         Ack_B,
  output logic         Done_A,
  output logic         Done_B,
  output logic         Found,
  output logic [7:0]   Max,
  output logic         Err,
  output logic         Eng_Mem_Wr,
  output logic [3:0]   Eng_Mem_Addr,
  output logic [7:0]   Eng_Mem_Data,
  output logic         Eng_Start,
  output logic         Eng_Ack,
  input  logic         Eng_Done_F,
  input  logic         Eng_Done_NF,
  input  logic [7:0]   Eng_Max,
  output logic         Busy
);

  localparam int S_IDLE  = 0;
  localparam int S_LOAD  = 1;
  localparam int S_START = 2;
  localparam int S_WAIT  = 3;
  localparam int S_RESP  = 4;
  localparam int S_ACK   = 5;

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    LOAD  = 6'b000010,
    START = 6'b000100,
    WAIT  = 6'b001000,
    RESP  = 6'b010000,
    ACK   = 6'b100000
  } state_t;

  state_t       state, state_nx;
  logic         gnt_b, gnt_nx;
  logic         ptr_b, ptr_nx;
  logic [3:0]   cnt, cnt_nx;
  logic [7:0]   max_nx;
  logic         found_nx;
  logic         pick_b;
  logic         ack_g;
  logic         eng_done;
  logic [127:0] img;

  // ptr_b high means B holds the round-robin pointer
  assign pick_b   = Req_B & (~Req_A | ptr_b);
  assign ack_g    = gnt_b ? Ack_B : Ack_A;
  assign eng_done = Eng_Done_F | Eng_Done_NF;
  assign img      = gnt_b ? Img_B : Img_A;

`ifdef DIV7_ARB_TIMEOUT_EN
  logic [7:0] wcnt, wcnt_nx;
  logic       err_q, err_nx;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      gnt_b <= 1'b0;
      ptr_b <= 1'b0;
      cnt   <= '0;
      Max   <= '0;
      Found <= 1'b0;
    end else begin
      state <= state_nx;
      gnt_b <= gnt_nx;
      ptr_b <= ptr_nx;
      cnt   <= cnt_nx;
      Max   <= max_nx;
      Found <= found_nx;
    end
  end

`ifdef DIV7_ARB_TIMEOUT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      wcnt  <= wcnt_nx;
      err_q <= err_nx;
    end
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_b;
    ptr_nx   = ptr_b;
    cnt_nx   = cnt;
    max_nx   = Max;
    found_nx = Found;
`ifdef DIV7_ARB_TIMEOUT_EN
    wcnt_nx  = wcnt;
    err_nx   = err_q;
`endif
    unique case (1'b1)
      state[S_IDLE]: begin
        if (Req_A || Req_B) begin
          gnt_nx   = pick_b;
          ptr_nx   = ~pick_b;
          cnt_nx   = '0;
          state_nx = LOAD;
        end
      end
      state[S_LOAD]: begin
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'd15) begin
          state_nx = START;
        end
      end
      state[S_START]: begin
`ifdef DIV7_ARB_TIMEOUT_EN
        wcnt_nx  = '0;
`endif
        state_nx = WAIT;
      end
      state[S_WAIT]: begin
        if (eng_done) begin
          max_nx   = Eng_Max;
          found_nx = Eng_Done_F;
          state_nx = RESP;
`ifdef DIV7_ARB_TIMEOUT_EN
        end else if (wcnt == 8'd254) begin
          // 255th idle WAIT cycle: abort with an empty result
          max_nx   = '0;
          found_nx = 1'b0;
          err_nx   = 1'b1;
          state_nx = RESP;
        end else begin
          wcnt_nx  = wcnt + 8'd1;
`endif
        end
      end
      state[S_RESP]: begin
        if (ack_g) begin
          state_nx = ACK;
        end
      end
      state[S_ACK]: begin
`ifdef DIV7_ARB_TIMEOUT_EN
        err_nx   = 1'b0;
`endif
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign Busy         = ~state[S_IDLE];
  assign Done_A       = state[S_RESP] & ~gnt_b;
  assign Done_B       = state[S_RESP] & gnt_b;
  assign Eng_Mem_Wr   = state[S_LOAD];
  assign Eng_Mem_Addr = state[S_LOAD] ? cnt : 4'd0;
  assign Eng_Mem_Data = state[S_LOAD] ? img[{cnt, 3'b000} +: 8] : 8'd0;
  assign Eng_Start    = state[S_START];
  assign Eng_Ack      = state[S_ACK];

endmodule

// File: tb/tb_div7_job_arbiter.sv
// tb_div7_job_arbiter: scoreboard bench with a behavioural div-by-7
// engine, auto-acking requesters and a grant-order reference model.
module tb_div7_job_arbiter;

  logic         Clk_tb;
  logic         Reset_n;
  logic         Req_A, Req_B;
  logic [127:0] Img_A, Img_B;
  logic         Ack_A, Ack_B;
  logic         Done_A, Done_B;
  logic         Found;
  logic [7:0]   Max;
  logic         Err;
  logic         Eng_Mem_Wr;
  logic [3:0]   Eng_Mem_Addr;
  logic [7:0]   Eng_Mem_Data;
  logic         Eng_Start, Eng_Ack;
  logic         Eng_Done_F, Eng_Done_NF;
  logic [7:0]   Eng_Max;
  logic         Busy;

  div7_job_arbiter dut (
    .Clk(Clk_tb), .Reset_n(Reset_n),
    .Req_A(Req_A), .Req_B(Req_B),
    .Img_A(Img_A), .Img_B(Img_B),
    .Ack_A(Ack_A), .Ack_B(Ack_B),
    .Done_A(Done_A), .Done_B(Done_B),
    .Found(Found), .Max(Max), .Err(Err),
    .Eng_Mem_Wr(Eng_Mem_Wr), .Eng_Mem_Addr(Eng_Mem_Addr),
    .Eng_Mem_Data(Eng_Mem_Data),
    .Eng_Start(Eng_Start), .Eng_Ack(Eng_Ack),
    .Eng_Done_F(Eng_Done_F), .Eng_Done_NF(Eng_Done_NF),
    .Eng_Max(Eng_Max), .Busy(Busy)
  );

  initial Clk_tb = 1'b0;
  always #5 Clk_tb = ~Clk_tb;

  typedef struct {
    bit       side;
    bit       found;
    bit [7:0] max;
    bit       err;
  } exp_t;

  localparam int M_COMP = 0;
  localparam int M_FORCE = 1;
  localparam int M_SILENT = 2;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         eng_mode = M_COMP;
  int         eng_lat = 1;
  bit         force_f, force_nf;
  bit [7:0]   force_max;
  bit         ptr_m = 1'b0;
  bit         hold_ack_a = 1'b0;
  int         wr_idx = 0;
  logic [7:0] mem[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, req);
    end
  endtask

  // Reference: largest byte divisible by 7, straight from the image
  function automatic exp_t ref_job(input bit side, input logic [127:0] im);
    exp_t e;
    bit [7:0] hits[$];
    e.side = side;
    e.err = 1'b0;
    for (int i = 0; i < 16; i++)
      if (im[8*i +: 8] % 7 == 0) hits.push_back(im[8*i +: 8]);
    if (eng_mode == M_FORCE) begin
      e.found = force_f;
      e.max = force_max;
    end else if (eng_mode == M_SILENT) begin
      e.found = 1'b0;
      e.max = 8'h00;
      e.err = 1'b1;
    end else if (hits.size() == 0) begin
      e.found = 1'b0;
      e.max = 8'hFF;
    end else begin
      hits.sort();
      e.found = 1'b1;
      e.max = hits[hits.size()-1];
    end
    return e;
  endfunction

  function automatic logic [127:0] rand_img(input bit nodiv);
    logic [127:0] v;
    bit [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      if (nodiv && (b % 7 == 0)) b = b + 8'd1;
      v[8*i +: 8] = b;
    end
    return v;
  endfunction

  task automatic push_side(input bit side);
    exp_q.push_back(ref_job(side, side ? Img_B : Img_A));
  endtask

  task automatic issue(input bit ra, input bit rb, input bit track);
    if (track) begin
      if (ra && rb) begin
        push_side(ptr_m);
        push_side(!ptr_m);
      end else if (ra) begin
        push_side(1'b0);
        ptr_m = 1'b1;
      end else begin
        push_side(1'b1);
        ptr_m = 1'b0;
      end
    end
    @(negedge Clk_tb);
    Req_A = ra;
    Req_B = rb;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(exp_q.size() == 0 && !Busy && !Ack_A && !Ack_B &&
             !Req_A && !Req_B) && n < 3000) begin
      @(negedge Clk_tb);
      n++;
    end
    chk("job_complete", {31'd0, n < 3000}, 32'd1);
  endtask

  task automatic lat_wait(output int cyc);
    cyc = 0;
    do begin
      @(posedge Clk_tb);
      cyc++;
      @(negedge Clk_tb);
      if (cyc == 2) Req_A = 1'b0;
    end while (!(Done_A || Done_B) && cyc < 400);
  endtask

  always @(posedge Clk_tb)
    if (Eng_Mem_Wr) mem[Eng_Mem_Addr] <= Eng_Mem_Data;

  initial begin : load_mon
    forever begin
      @(negedge Clk_tb);
      if (Eng_Mem_Wr) begin
        chk("load_addr", {28'd0, Eng_Mem_Addr}, wr_idx);
        wr_idx++;
      end
    end
  end

  initial begin : engine
    bit f;
    bit [7:0] m;
    Eng_Done_F = 1'b0;
    Eng_Done_NF = 1'b0;
    Eng_Max = 8'h00;
    forever begin
      @(negedge Clk_tb);
      if (Eng_Start) begin
        chk("load_count", wr_idx, 32'd16);
        wr_idx = 0;
        if (eng_mode != M_SILENT) begin
          repeat (eng_lat) @(negedge Clk_tb);
          if (eng_mode == M_FORCE) begin
            Eng_Done_F = force_f;
            Eng_Done_NF = force_nf;
            Eng_Max = force_max;
          end else begin
            f = 1'b0;
            m = 8'h00;
            for (int i = 0; i < 16; i++)
              if (mem[i] % 7 == 0) begin
                f = 1'b1;
                if (mem[i] > m) m = mem[i];
              end
            Eng_Done_F = f;
            Eng_Done_NF = !f;
            Eng_Max = f ? m : 8'hFF;
          end
          @(negedge Clk_tb);
          Eng_Done_F = 1'b0;
          Eng_Done_NF = 1'b0;
          Eng_Max = 8'($urandom);
        end
      end
    end
  end

  initial begin : ack_a
    forever begin
      @(negedge Clk_tb);
      if (Done_A && !Ack_A && !hold_ack_a) begin
        Req_A = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge Clk_tb);
        Ack_A = 1'b1;
        @(negedge Clk_tb);
        Ack_A = 1'b0;
      end
    end
  end

  initial begin : ack_b
    forever begin
      @(negedge Clk_tb);
      if (Done_B && !Ack_B) begin
        Req_B = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge Clk_tb);
        Ack_B = 1'b1;
        @(negedge Clk_tb);
        Ack_B = 1'b0;
      end
    end
  end

  initial begin : monitor
    bit seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge Clk_tb);
      if (!(Done_A || Done_B)) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_side", {30'd0, Done_B, Done_A},
              e.side ? 32'd2 : 32'd1);
          chk("found", {31'd0, Found}, {31'd0, e.found});
          chk("max", {24'd0, Max}, {24'd0, e.max});
          chk("err", {31'd0, Err}, {31'd0, e.err});
        end
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return {4'd0, Done_A, Done_B, Found, Max, Err, Eng_Mem_Wr,
            Eng_Mem_Addr, Eng_Mem_Data, Eng_Start, Eng_Ack, Busy};
  endfunction

  initial begin : watchdog
    #5000000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1, "global timeout");
  end

  initial begin : driver
    int cyc;
    int n;
    int r;
    Reset_n = 1'b1;
    Req_A = 1'b0;
    Req_B = 1'b0;
    Ack_A = 1'b0;
    Ack_B = 1'b0;
    Img_A = '0;
    Img_B = '0;
    #2 Reset_n = 1'b0;
    repeat (3) @(negedge Clk_tb);
    chk("reset_outs", all_outs(), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk_tb);
    chk("post_reset_outs", all_outs(), 32'd0);

    // known image, engine reports found with 0x93; Req_A dropped early
    eng_mode = M_FORCE;
    force_f = 1'b1;
    force_nf = 1'b0;
    force_max = 8'h93;
    eng_lat = 3;
    Img_A = 128'h128493049302850E3423839004649734;
    issue(1'b1, 1'b0, 1'b1);
    lat_wait(cyc);
    chk("latency_n3", cyc, 32'd21);
    wait_done();
    chk("mem_addr0", {24'd0, mem[0]}, 32'h34);
    chk("mem_addr15", {24'd0, mem[15]}, 32'h12);
    chk("held_result", {23'd0, Found, Max}, 32'h193);

    // B job, engine reports not-found
    force_f = 1'b0;
    force_nf = 1'b1;
    force_max = 8'h5C;
    eng_lat = 2;
    Img_B = 128'h00013953006873916139295960395673;
    issue(1'b0, 1'b1, 1'b1);
    wait_done();

    // both done inputs high must read as found
    force_f = 1'b1;
    force_nf = 1'b1;
    force_max = 8'hA7;
    issue(1'b1, 1'b0, 1'b1);
    wait_done();

    // foreign Ack_B while A sits in RESP
    hold_ack_a = 1'b1;
    force_f = 1'b1;
    force_nf = 1'b0;
    force_max = 8'h3F;
    issue(1'b1, 1'b0, 1'b1);
    n = 0;
    while (!Done_A && n < 400) begin
      @(negedge Clk_tb);
      n++;
    end
    chk("reach_resp", {31'd0, Done_A}, 32'd1);
    Ack_B = 1'b1;
    repeat (4) @(negedge Clk_tb);
    chk("done_a_held", {30'd0, Done_A, Eng_Ack}, 32'd2);
    Ack_B = 1'b0;
    hold_ack_a = 1'b0;
    wait_done();

    // reset mid-LOAD at address 7
    eng_mode = M_COMP;
    eng_lat = 1;
    Img_A = rand_img(1'b0);
    issue(1'b1, 1'b0, 1'b0);
    n = 0;
    while (!(Eng_Mem_Wr && Eng_Mem_Addr == 4'd7) && n < 100) begin
      @(negedge Clk_tb);
      n++;
    end
    chk("reach_addr7", {28'd0, Eng_Mem_Addr}, 32'd7);
    #1 Reset_n = 1'b0;
    Req_A = 1'b0;
    #1 chk("abort_outs", all_outs(), 32'd0);
    repeat (2) @(negedge Clk_tb);
    chk("abort_outs_held", all_outs(), 32'd0);
    Reset_n = 1'b1;
    wr_idx = 0;
    ptr_m = 1'b0;
    @(negedge Clk_tb);
    chk("abort_idle", {31'd0, Busy}, 32'd0);

    // simultaneous requests after reset: A, B, then A again
    Img_A = rand_img(1'b0);
    Img_B = rand_img(1'b1);
    issue(1'b1, 1'b1, 1'b1);
    wait_done();
    Img_A = rand_img(1'b1);
    Img_B = rand_img(1'b0);
    issue(1'b1, 1'b1, 1'b1);
    wait_done();

    for (int k = 0; k < 40; k++) begin
      eng_mode = ($urandom_range(0, 1) == 0) ? M_COMP : M_FORCE;
      r = $urandom_range(1, 3);
      force_f = r[0];
      force_nf = r[1];
      force_max = 8'($urandom);
      eng_lat = $urandom_range(1, 6);
      Img_A = rand_img($urandom_range(0, 2) == 0);
      Img_B = rand_img($urandom_range(0, 2) == 0);
      r = $urandom_range(1, 3);
      issue(r[0], r[1], 1'b1);
      wait_done();
    end

    // silent engine
    eng_mode = M_SILENT;
    Img_A = rand_img(1'b0);
`ifdef DIV7_ARB_TIMEOUT_EN
    issue(1'b1, 1'b0, 1'b1);
    lat_wait(cyc);
    chk("timeout_latency", cyc, 32'd273);
    wait_done();
    chk("err_cleared", {31'd0, Err}, 32'd0);
`else
    issue(1'b1, 1'b0, 1'b0);
    repeat (600) @(negedge Clk_tb);
    chk("wait_unbounded", {29'd0, Busy, Done_A, Err}, 32'd4);
    Reset_n = 1'b0;
    Req_A = 1'b0;
    @(negedge Clk_tb);
    Reset_n = 1'b1;
    wr_idx = 0;
    @(negedge Clk_tb);
    chk("silent_abort", all_outs(), 32'd0);
`endif
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
